pattern_detector: RTL and testbench
===================================

# pattern_detector

Byte-serial pattern checker placed downstream of the PRBS generator. It compares the 8-bit PRBS output stream, one byte per clock, against a programmable 32-bit pattern sent most-significant byte first. It counts back-to-back complete pattern occurrences and raises a sticky detect flag once the count reaches a programmable repetition target `n`.

## Interface
- Parameters: none. Widths are fixed: 32-bit pattern, 8-bit byte, 4-bit repetition count.
- `clk` — input, 1 — single clock; all state updates on the rising edge.
- `rst` — input, 1 — reset, asynchronous and active-low.
- `pattern` — input, 32 — pattern to detect; byte order on the stream is [31:24], [23:16], [15:8], [7:0].
- `n` — input, 4 — required number of consecutive pattern repetitions; 0 behaves as 1.
- `prbs_out` — input, 8 — incoming stream byte, sampled every rising edge.
- `pattern_detected` — output, 1 — registered, sticky detect flag.

## Operation
- State:
  - `byte_idx` (2 bits, 0..3): the next expected pattern byte.
  - `rep_cnt` (4 bits, saturating at 15): completed consecutive repetitions.
  - `pattern_detected` register.
- Every edge, compare `prbs_out` with `pattern` byte `byte_idx`. An X/Z on `prbs_out` counts as a mismatch.
- Match with `byte_idx` < 3: `byte_idx` increments.
- Match with `byte_idx` == 3:
  - `byte_idx` becomes 0.
  - `rep_cnt` increments, saturating.
  - If the new count ≥ max(`n`, 1), `pattern_detected` is set.
- Mismatch:
  - `rep_cnt` is cleared to 0.
  - `byte_idx` becomes 1 if `prbs_out` equals `pattern[31:24]` (restart on a fresh first byte), otherwise 0.
  - There is no other partial-overlap recovery.
- Sticky flag: once set, `pattern_detected` stays 1 until reset, regardless of later mismatches. Counting continues internally but has no visible effect.
- `pattern` and `n` are used combinationally each cycle. Changing them mid-stream takes effect on the next compare, and the partial state is not cleared. Callers hold them stable while detection runs.
- Identical adjacent pattern bytes (for example 32'hA5A5A5A5) need no special handling. The in-order rules above apply as written.

## Timing
- Reset (`rst`=0, asynchronous): `byte_idx`=0, `rep_cnt`=0, `pattern_detected`=0 immediately. Comparison starts at the first rising edge after deassertion.
- Latency: `pattern_detected` goes high on the same rising edge that samples the final byte (`pattern[7:0]`) of the n-th consecutive repetition. It is visible right after that edge, with no extra pipeline stage.
- Reset asserted mid-stream discards all partial progress and clears the flag at once. After release, detection restarts from `byte_idx` 0.
- No handshake: every edge consumes exactly one byte.

## Structure
- Shared package `prbs_pkg` holds:
  - `BYTE_W`=8, `PAT_W`=32, `PAT_BYTES`=4, `REP_W`=4;
  - a typedef for the byte index and one for the repetition counter.
- One natural sub-module, `pattern_byte_sel`: a combinational mux that returns `pattern` byte k for index k, MSB-first. It is used both for the expected-byte compare and for the byte-0 restart compare.
- Top level holds the index/counter state machine and the flag register.

## Test plan
- Reset, `pattern`=32'hA5A6A7A8, `n`=3, stream A5 A6 A7 A8 ×3 → flag 0 through the first 11 bytes; 1 right after the edge sampling the 12th byte (A8); stays 1 for later idle cycles.
- Same setup, stream B5 B6 B7 B8 then one A5 A6 A7 A8 → flag stays 0 (count 1 < 3).
- `n`=2, stream A5 A6 A7 A8, A5 A6 00 A8, A5 A6 A7 A8, A5 A6 A7 A8 → the mismatch clears the count; flag rises only on the final A8.
- Mismatch restart: `n`=1, stream A5 A6 A5 A6 A7 A8 → the A5 after the break restarts at index 1; flag rises on the final A8.
- `n`=0, one full A5 A6 A7 A8 → flag rises on the A8 (treated as `n`=1).
- Flag high, then `rst` pulsed low for 1 ns between edges → flag 0 immediately; a new detection requires `n` fresh repetitions.

Source files
------------

// File: rtl/prbs_pkg.sv
// ---------------------------------------------------------------------------
// prbs_pkg
// Shared widths and types for the PRBS pattern-checking slice.
//   BYTE_W    : stream byte width
//   PAT_W     : programmable pattern width
//   PAT_BYTES : bytes per pattern occurrence
//   REP_W     : repetition counter / target width
// ---------------------------------------------------------------------------
package prbs_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned PAT_W     = 32;
    localparam int unsigned PAT_BYTES = 4;
    localparam int unsigned REP_W     = 4;

    typedef logic [1:0]       byte_idx_t;
    typedef logic [REP_W-1:0] rep_cnt_t;

    localparam byte_idx_t LAST_IDX = byte_idx_t'(PAT_BYTES - 1);
    localparam rep_cnt_t  REP_MAX  = '1;

endpackage

// File: rtl/pattern_byte_sel.sv
// ---------------------------------------------------------------------------
// pattern_byte_sel
// Combinational selector returning byte `idx` of `pattern`, MSB first
// (idx 0 -> pattern[31:24], idx 3 -> pattern[7:0]).
//   pattern  : 32-bit pattern
//   idx      : byte index 0..3
//   sel_byte : selected pattern byte
// ---------------------------------------------------------------------------
module pattern_byte_sel
    import prbs_pkg::*;
(
    input  logic [PAT_W-1:0]  pattern,
    input  byte_idx_t         idx,
    output logic [BYTE_W-1:0] sel_byte
);

    always_comb begin
        sel_byte = '0;
        case (idx)
            2'd0:    sel_byte = pattern[31:24];
            2'd1:    sel_byte = pattern[23:16];
            2'd2:    sel_byte = pattern[15:8];
            2'd3:    sel_byte = pattern[7:0];
            default: sel_byte = '0;
        endcase
    end

endmodule

// File: rtl/pattern_detector.sv
// ---------------------------------------------------------------------------
// pattern_detector
// Byte-serial checker for a 32-bit pattern sent MSB byte first. Counts
// back-to-back complete occurrences and raises a sticky flag once the
// count reaches max(n, 1).
//   clk              : clock, rising edge
//   rst              : asynchronous active-low reset
//   pattern          : pattern to detect
//   n                : required consecutive repetitions (0 behaves as 1)
//   prbs_out         : stream byte, consumed every edge
//   pattern_detected : registered sticky detect flag
// ---------------------------------------------------------------------------
module pattern_detector
    import prbs_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [PAT_W-1:0]  pattern,
    input  logic [REP_W-1:0]  n,
    input  logic [BYTE_W-1:0] prbs_out,
    output logic              pattern_detected
);

    byte_idx_t         byte_idx;
    rep_cnt_t          rep_cnt;
    logic [BYTE_W-1:0] exp_byte;
    logic [BYTE_W-1:0] first_byte;
    rep_cnt_t          next_cnt;
    rep_cnt_t          target;

    pattern_byte_sel u_sel_exp (
        .pattern  (pattern),
        .idx      (byte_idx),
        .sel_byte (exp_byte)
    );

    pattern_byte_sel u_sel_first (
        .pattern  (pattern),
        .idx      (2'd0),
        .sel_byte (first_byte)
    );

    always_comb begin
        next_cnt = (rep_cnt == REP_MAX) ? REP_MAX : rep_cnt + 4'd1;
        target   = (n == '0) ? 4'd1 : n;
    end

    // Compares are written as if/else so an unknown stream byte falls into
    // the mismatch branch and restarts from index 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx         <= '0;
            rep_cnt          <= '0;
            pattern_detected <= 1'b0;
        end else begin
            if (prbs_out == exp_byte) begin
                if (byte_idx == LAST_IDX) begin
                    byte_idx <= '0;
                    rep_cnt  <= next_cnt;
                    if (next_cnt >= target)
                        pattern_detected <= 1'b1;
                end else begin
                    byte_idx <= byte_idx + 2'd1;
                end
            end else begin
                rep_cnt <= '0;
                if (prbs_out == first_byte)
                    byte_idx <= 2'd1;
                else
                    byte_idx <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_pattern_detector.sv
module tb_pattern_detector;

    logic        clk;
    logic        rst;
    logic [31:0] pattern;
    logic [3:0]  n;
    logic [7:0]  prbs_out;
    logic        pattern_detected;

    int unsigned passed;
    int unsigned total;

    pattern_detector dut (
        .clk              (clk),
        .rst              (rst),
        .pattern          (pattern),
        .n                (n),
        .prbs_out         (prbs_out),
        .pattern_detected (pattern_detected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic exp);
        total++;
        assert (pattern_detected === exp) passed++;
        else $error("FAIL %s: pattern_detected=%b expected=%b", tag, pattern_detected, exp);
    endtask

    // Present a byte at the falling edge, let the rising edge sample it,
    // then check the flag 1 ns later.
    task automatic send_chk(input logic [7:0] b, input logic exp, input string tag);
        @(negedge clk);
        prbs_out = b;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    // Short reset pulse placed between edges; flag must clear at once.
    task automatic rst_pulse(input string tag);
        @(negedge clk);
        prbs_out = 8'h00;
        #2 rst = 1'b0;
        #1;
        check(tag, 1'b0);
        rst = 1'b1;
    endtask

    logic [7:0] seq [0:15];

    initial begin
        passed   = 0;
        total    = 0;
        rst      = 1'b0;
        pattern  = 32'hA5A6A7A8;
        n        = 4'd3;
        prbs_out = 8'h00;
        #12;
        check("reset_state", 1'b0);
        rst = 1'b1;

        // Three back-to-back repetitions with n=3: flag only on the 12th byte.
        seq[0] = 8'hA5; seq[1] = 8'hA6; seq[2] = 8'hA7; seq[3] = 8'hA8;
        for (int i = 0; i < 12; i++)
            send_chk(seq[i % 4], (i == 11), $sformatf("n3_byte%0d", i));
        send_chk(8'h00, 1'b1, "n3_sticky0");
        send_chk(8'h13, 1'b1, "n3_sticky1");

        // Wrong pattern then one good repetition: count 1 < 3.
        rst_pulse("rst_before_t2");
        seq[0] = 8'hB5; seq[1] = 8'hB6; seq[2] = 8'hB7; seq[3] = 8'hB8;
        seq[4] = 8'hA5; seq[5] = 8'hA6; seq[6] = 8'hA7; seq[7] = 8'hA8;
        for (int i = 0; i < 8; i++)
            send_chk(seq[i], 1'b0, $sformatf("t2_byte%0d", i));

        // n=2 with a broken middle repetition clearing the count.
        rst_pulse("rst_before_t3");
        n = 4'd2;
        seq[0]  = 8'hA5; seq[1]  = 8'hA6; seq[2]  = 8'hA7; seq[3]  = 8'hA8;
        seq[4]  = 8'hA5; seq[5]  = 8'hA6; seq[6]  = 8'h00; seq[7]  = 8'hA8;
        seq[8]  = 8'hA5; seq[9]  = 8'hA6; seq[10] = 8'hA7; seq[11] = 8'hA8;
        seq[12] = 8'hA5; seq[13] = 8'hA6; seq[14] = 8'hA7; seq[15] = 8'hA8;
        for (int i = 0; i < 16; i++)
            send_chk(seq[i], (i == 15), $sformatf("t3_byte%0d", i));

        // Restart on a fresh first byte after a break, n=1.
        rst_pulse("rst_before_t4");
        n = 4'd1;
        seq[0] = 8'hA5; seq[1] = 8'hA6; seq[2] = 8'hA5;
        seq[3] = 8'hA6; seq[4] = 8'hA7; seq[5] = 8'hA8;
        for (int i = 0; i < 6; i++)
            send_chk(seq[i], (i == 5), $sformatf("t4_byte%0d", i));

        // n=0 behaves as 1.
        rst_pulse("rst_before_t5");
        n = 4'd0;
        seq[0] = 8'hA5; seq[1] = 8'hA6; seq[2] = 8'hA7; seq[3] = 8'hA8;
        for (int i = 0; i < 4; i++)
            send_chk(seq[i], (i == 3), $sformatf("t5_byte%0d", i));

        // Flag high, reset pulse clears it; n=2 needs two fresh repetitions.
        n = 4'd2;
        rst_pulse("t6_rst_clears");
        for (int i = 0; i < 8; i++)
            send_chk(seq[i % 4], (i == 7), $sformatf("t6_byte%0d", i));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
